// File: rtl/reg_file_pkg.sv
// Shared definitions for the MIPS register file: default widths, register
// count and the hardwired zero register address.
package reg_file_pkg;

  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file. Priority, highest first:
// zero register, same-cycle write bypass, stored array contents.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_bypass_en,
  input  logic [DATA_W-1:0] i_array_data,
  output logic [DATA_W-1:0] o_rdata
);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (i_raddr == ADDR_W'(ZERO_REG));
  assign w_hit     = i_bypass_en && (i_raddr == i_waddr);

  // Select read data: zero-force, then bypass of the pending write, then array.
  always_comb begin
    o_rdata = '0;
    if (w_is_zero) begin
      o_rdata = '0;
    end else if (w_hit) begin
      o_rdata = i_wdata;
    end else begin
      o_rdata = i_array_data;
    end
  end

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// 32 x DATA_W register file: two combinational read ports with write-through
// bypass, one synchronous write port, register 0 hardwired to zero.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  input  logic [ADDR_W-1:0] W1,
  input  logic [DATA_W-1:0] D1,
  output logic [DATA_W-1:0] Out1,
  output logic [DATA_W-1:0] Out2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] w_arr1;
  logic [DATA_W-1:0] w_arr2;
  logic              w_wr_en;

  // W1 == 0 doubles as the "no write" encoding; there is no separate enable.
  assign w_wr_en = (W1 != ADDR_W'(ZERO_REG));

  // Storage: async clear on reset, one write per rising edge otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[W1] <= D1;
    end
  end

  assign w_arr1 = r_regs[R1];
  assign w_arr2 = r_regs[R2];

  // The bypass is gated by reset_n so reads during reset see the cleared array.
  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port1 (
    .i_raddr      (R1),
    .i_waddr      (W1),
    .i_wdata      (D1),
    .i_bypass_en  (reset_n),
    .i_array_data (w_arr1),
    .o_rdata      (Out1)
  );

  reg_file_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_port2 (
    .i_raddr      (R2),
    .i_waddr      (W1),
    .i_wdata      (D1),
    .i_bypass_en  (reset_n),
    .i_array_data (w_arr2),
    .o_rdata      (Out2)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: the stimulus process drives inputs at the
// falling edge and queues the expected read data; a monitor pops and compares.
module tb_reg_file;

  logic        clk;
  logic        reset_n;
  logic [4:0]  R1, R2, W1;
  logic [31:0] D1;
  logic [31:0] Out1, Out2;

  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  reg_file #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .R1      (R1),
    .R2      (R2),
    .W1      (W1),
    .D1      (D1),
    .Out1    (Out1),
    .Out2    (Out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rn, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] w1, input logic [31:0] d1);
    reset_n = rn;
    R1 = r1;
    R2 = r2;
    W1 = w1;
    D1 = d1;
  endtask

  // Let combinational outputs settle, queue the expectation, hold inputs briefly.
  task automatic expect_out(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    #1;
    e.name = name;
    e.e1   = e1;
    e.e2   = e2;
    q.push_back(e);
    #1;
  endtask

  // Monitor: compares the live outputs whenever an expectation is queued.
  initial begin
    exp_t e;
    forever begin
      wait (q.size() > 0);
      e = q.pop_front();
      n_checks++;
      if (Out1 !== e.e1) begin
        n_fail++;
        $display("FAIL %s Out1: got %h expected %h", e.name, Out1, e.e1);
      end
      n_checks++;
      if (Out2 !== e.e2) begin
        n_fail++;
        $display("FAIL %s Out2: got %h expected %h", e.name, Out2, e.e2);
      end
    end
  end

  // Stimulus
  initial begin
    drive(1'b0, 5'd3, 5'd6, 5'd0, 32'h0);
    expect_out("reset_hold", 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd3, 5'd6, 5'd3, 32'hAAAA_AAAA);
    expect_out("reset_no_bypass", 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b0, 5'd3, 5'd6, 5'd0, 32'h0);
    expect_out("reset_no_write", 32'h0, 32'h0);

    @(negedge clk);
    drive(1'b1, 5'd3, 5'd6, 5'd0, 32'h0);
    expect_out("post_reset", 32'h0, 32'h0);

    @(negedge clk);
    drive(1'b1, 5'd5, 5'd5, 5'd5, 32'h5);
    expect_out("wr5_bypass", 32'h5, 32'h5);
    @(negedge clk);
    drive(1'b1, 5'd5, 5'd5, 5'd0, 32'h0);
    expect_out("wr5_array", 32'h5, 32'h5);

    @(negedge clk);
    drive(1'b1, 5'd7, 5'd5, 5'd7, 32'hDEAD_BEEF);
    expect_out("bypass7", 32'hDEAD_BEEF, 32'h5);
    @(negedge clk);
    drive(1'b1, 5'd7, 5'd5, 5'd0, 32'h0);
    expect_out("array7", 32'hDEAD_BEEF, 32'h5);

    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
    expect_out("zero_same_cycle", 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    drive(1'b1, 5'd0, 5'd7, 5'd0, 32'hFFFF_FFFF);
    expect_out("zero_after_edges", 32'h0, 32'hDEAD_BEEF);

    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd1, 32'h11);
    @(negedge clk);
    drive(1'b1, 5'd0, 5'd0, 5'd31, 32'h1F);
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd31, 5'd0, 32'h0);
    expect_out("ports_1_31", 32'h11, 32'h1F);
    @(negedge clk);
    drive(1'b1, 5'd31, 5'd1, 5'd0, 32'h0);
    expect_out("ports_swapped", 32'h1F, 32'h11);
    @(negedge clk);
    drive(1'b1, 5'd31, 5'd31, 5'd0, 32'h0);
    expect_out("same_addr", 32'h1F, 32'h1F);

    @(negedge clk);
    drive(1'b1, 5'd1, 5'd31, 5'd1, 32'h22);
    expect_out("overwrite_bypass", 32'h22, 32'h1F);
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd31, 5'd0, 32'h0);
    expect_out("overwrite_array", 32'h22, 32'h1F);

    // Reset pulse confined between two rising edges.
    @(negedge clk);
    drive(1'b0, 5'd1, 5'd31, 5'd0, 32'h0);
    expect_out("async_reset_1_31", 32'h0, 32'h0);
    R1 = 5'd7;
    R2 = 5'd5;
    expect_out("async_reset_7_5", 32'h0, 32'h0);
    reset_n = 1'b1;
    expect_out("reset_released", 32'h0, 32'h0);
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd31, 5'd0, 32'h0);
    expect_out("cleared_after_edge", 32'h0, 32'h0);

    @(negedge clk);
    drive(1'b1, 5'd9, 5'd5, 5'd9, 32'h99);
    @(negedge clk);
    drive(1'b1, 5'd9, 5'd5, 5'd0, 32'h0);
    expect_out("rewrite_after_reset", 32'h99, 32'h0);

    stim_done = 1'b1;
  end

  // Drain the scoreboard with a bounded wait, then summarise.
  initial begin
    int guard;
    guard = 0;
    wait (stim_done);
    while (q.size() > 0 && guard < 100) begin
      #1;
      guard++;
    end
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: stimulus did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_reg_file
